// File: rtl/gpr_file_if.sv
// Bus bundle for the GPR file: read ports, two write-back ports, issue/flush
// controls, the debug read port and the pending counter.
interface gpr_file_if #(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    parameter int NRP  = 2
);
    localparam int CW = $clog2(NREG + 1);

    logic [5*NRP-1:0]    rd_addr;
    logic [XLEN*NRP-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wb0_en;
    logic [4:0]          wb0_addr;
    logic [XLEN-1:0]     wb0_data;
    logic                wb1_en;
    logic [4:0]          wb1_addr;
    logic [XLEN-1:0]     wb1_data;
    logic                iss_en;
    logic [4:0]          iss_addr;
    logic                flush;
    logic [4:0]          dbg_addr;
    logic [XLEN-1:0]     dbg_data;
    logic [CW-1:0]       pend_cnt;

    // Pipeline side: drives addresses and strobes, receives read results.
    modport master (
        output rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
               iss_en, iss_addr, flush, dbg_addr,
        input  rd_data, rd_busy, dbg_data, pend_cnt
    );

    // Register file side.
    modport slave (
        input  rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
               iss_en, iss_addr, flush, dbg_addr,
        output rd_data, rd_busy, dbg_data, pend_cnt
    );
endinterface

// File: rtl/gpr_file.sv
// General-purpose register file with write-back scoreboard.
// Two write-back ports (wb1 wins on collision), per-register pending bits set
// on issue and cleared on write-back or flush, optional write-to-read bypass.
module gpr_file #(
    parameter int XLEN   = 32,
    parameter int NREG   = 16,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    gpr_file_if.slave  bus
);
    localparam int         CW     = $clog2(NREG + 1);
    localparam int         IW     = $clog2(NREG);
    localparam logic [5:0] NREG_W = 6'(NREG);
    localparam logic       BYP    = (BYPASS != 0);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] pend_r;
    logic [NREG-1:0] pend_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [NREG-1:0] wb0_vec_s;
    logic [NREG-1:0] wb1_vec_s;
    logic [NREG-1:0] iss_vec_s;

    // x0 and addresses beyond the implemented register count are inert.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < NREG_W);
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // One-hot decode of the write-back and issue targets.
    always_comb begin
        wb0_vec_s = {NREG{1'b0}};
        wb1_vec_s = {NREG{1'b0}};
        iss_vec_s = {NREG{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            wb0_vec_s[r] = bus.wb0_en && addr_ok(bus.wb0_addr) && (bus.wb0_addr == 5'(r));
            wb1_vec_s[r] = bus.wb1_en && addr_ok(bus.wb1_addr) && (bus.wb1_addr == 5'(r));
            iss_vec_s[r] = bus.iss_en && addr_ok(bus.iss_addr) && (bus.iss_addr == 5'(r));
        end
    end

    // Next pending vector: issue beats flush, flush beats write-back clear.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int r = 0; r < NREG; r++) begin
            if (iss_vec_s[r]) begin
                pend_nxt_s[r] = 1'b1;
            end else if (bus.flush) begin
                pend_nxt_s[r] = 1'b0;
            end else if (wb0_vec_s[r] || wb1_vec_s[r]) begin
                pend_nxt_s[r] = 1'b0;
            end else begin
                pend_nxt_s[r] = pend_r[r];
            end
        end
    end

    // Register storage; the LSU port wins when both ports target one register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb1_vec_s[i]) begin
                    regs_r[i] <= bus.wb1_data;
                end else if (wb0_vec_s[i]) begin
                    regs_r[i] <= bus.wb0_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Pending vector and its population count, kept in lockstep.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend_r <= {NREG{1'b0}};
            cnt_r  <= {CW{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
            cnt_r  <= popcount(pend_nxt_s);
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [4:0]      a_s;
        logic [IW-1:0]   idx_s;
        logic            w0_s;
        logic            w1_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        // Read port k: optional forwarding of same-cycle write-back data and clear.
        always_comb begin
            a_s    = bus.rd_addr[5*k +: 5];
            idx_s  = a_s[IW-1:0];
            w0_s   = bus.wb0_en && (bus.wb0_addr == a_s);
            w1_s   = bus.wb1_en && (bus.wb1_addr == a_s);
            data_s = {XLEN{1'b0}};
            busy_s = 1'b0;
            if (addr_ok(a_s)) begin
                if (BYP && w1_s) begin
                    data_s = bus.wb1_data;
                end else if (BYP && w0_s) begin
                    data_s = bus.wb0_data;
                end else begin
                    data_s = regs_r[idx_s];
                end
                busy_s = pend_r[idx_s] && !(BYP && (w0_s || w1_s));
            end else begin
                data_s = {XLEN{1'b0}};
                busy_s = 1'b0;
            end
        end

        assign bus.rd_data[XLEN*k +: XLEN] = data_s;
        assign bus.rd_busy[k]              = busy_s;
    end

    logic [XLEN-1:0] dbg_s;

    // Debug port shows committed state only, never forwarded data.
    always_comb begin
        if (addr_ok(bus.dbg_addr)) begin
            dbg_s = regs_r[bus.dbg_addr[IW-1:0]];
        end else begin
            dbg_s = {XLEN{1'b0}};
        end
    end

    assign bus.dbg_data = dbg_s;
    assign bus.pend_cnt = cnt_r;
endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: one RV32E/bypassing instance (A) and one
// RV32I/non-bypassing instance (B) see identical stimulus; expected values are
// queued when stimulus is applied and compared when outputs are sampled.
module tb_gpr_file;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [9:0]  rd_addr;
    logic        wb0_en, wb1_en, iss_en, flush;
    logic [4:0]  wb0_addr, wb1_addr, iss_addr, dbg_addr;
    logic [31:0] wb0_data, wb1_data;

    gpr_file_if #(.XLEN(32), .NREG(16), .NRP(2)) ifa ();
    gpr_file_if #(.XLEN(32), .NREG(32), .NRP(2)) ifb ();

    assign ifa.rd_addr = rd_addr;   assign ifb.rd_addr = rd_addr;
    assign ifa.wb0_en = wb0_en;     assign ifb.wb0_en = wb0_en;
    assign ifa.wb0_addr = wb0_addr; assign ifb.wb0_addr = wb0_addr;
    assign ifa.wb0_data = wb0_data; assign ifb.wb0_data = wb0_data;
    assign ifa.wb1_en = wb1_en;     assign ifb.wb1_en = wb1_en;
    assign ifa.wb1_addr = wb1_addr; assign ifb.wb1_addr = wb1_addr;
    assign ifa.wb1_data = wb1_data; assign ifb.wb1_data = wb1_data;
    assign ifa.iss_en = iss_en;     assign ifb.iss_en = iss_en;
    assign ifa.iss_addr = iss_addr; assign ifb.iss_addr = iss_addr;
    assign ifa.flush = flush;       assign ifb.flush = flush;
    assign ifa.dbg_addr = dbg_addr; assign ifb.dbg_addr = dbg_addr;

    gpr_file #(.XLEN(32), .NREG(16), .NRP(2), .BYPASS(1)) dut_a (
        .sys_clk(clk), .sys_rst(rst), .bus(ifa.slave));
    gpr_file #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .bus(ifb.slave));

    localparam int F_RD0 = 0, F_RD1 = 1, F_BUSY0 = 2, F_BUSY1 = 3, F_DBG = 4, F_CNT = 5;
    localparam int DA = 0, DB = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            DA + F_RD0:   return ifa.rd_data[31:0];
            DA + F_RD1:   return ifa.rd_data[63:32];
            DA + F_BUSY0: return {31'd0, ifa.rd_busy[0]};
            DA + F_BUSY1: return {31'd0, ifa.rd_busy[1]};
            DA + F_DBG:   return ifa.dbg_data;
            DA + F_CNT:   return 32'(ifa.pend_cnt);
            DB + F_RD0:   return ifb.rd_data[31:0];
            DB + F_RD1:   return ifb.rd_data[63:32];
            DB + F_BUSY0: return {31'd0, ifb.rd_busy[0]};
            DB + F_BUSY1: return {31'd0, ifb.rd_busy[1]};
            DB + F_DBG:   return ifb.dbg_data;
            DB + F_CNT:   return 32'(ifb.pend_cnt);
            default:      return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] e);
        exp_t item;
        item.tag = tag;
        item.sel = sel;
        item.exp = e;
        exp_q.push_back(item);
    endtask

    task automatic push2(input string tag, input int field, input logic [31:0] e);
        push({"A.", tag}, DA + field, e);
        push({"B.", tag}, DB + field, e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [31:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        wb0_en = 1'b0; wb1_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = 10'd0; dbg_addr = 5'd0;
        wb0_addr = 5'd0; wb1_addr = 5'd0; iss_addr = 5'd0;
        wb0_data = 32'd0; wb1_data = 32'd0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state on every address and port.
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rd_addr = {5'(a), 5'(a)};
            dbg_addr = 5'(a);
            push2("rst_rd0", F_RD0, 32'd0);
            push2("rst_rd1", F_RD1, 32'd0);
            push2("rst_busy0", F_BUSY0, 32'd0);
            push2("rst_busy1", F_BUSY1, 32'd0);
            push2("rst_dbg", F_DBG, 32'd0);
            push2("rst_cnt", F_CNT, 32'd0);
            check_all();
        end

        // Writes to x0 are discarded.
        @(negedge clk);
        wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hDEAD_BEEF;
        rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
        push2("x0_bypass", F_RD0, 32'd0);
        check_all();
        @(negedge clk);
        idle();
        push2("x0_rd", F_RD0, 32'd0);
        push2("x0_dbg", F_DBG, 32'd0);
        check_all();

        // Same-address collision: wb1 wins.
        @(negedge clk);
        wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h1111_1111;
        wb1_en = 1'b1; wb1_addr = 5'd5; wb1_data = 32'h2222_2222;
        rd_addr = {5'd0, 5'd5};
        push("A.coll_byp", DA + F_RD0, 32'h2222_2222);
        push("B.coll_nobyp", DB + F_RD0, 32'd0);
        check_all();
        @(negedge clk);
        idle();
        dbg_addr = 5'd5;
        push2("coll_dbg", F_DBG, 32'h2222_2222);
        push2("coll_rd", F_RD0, 32'h2222_2222);
        check_all();

        // Issue x7, hold three cycles, then LSU write-back.
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd7;
        rd_addr = {5'd7, 5'd5};
        push2("iss_same_cyc", F_BUSY1, 32'd0);
        check_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            push2("iss_busy", F_BUSY1, 32'd1);
            push2("iss_cnt", F_CNT, 32'd1);
            check_all();
        end
        @(negedge clk);
        wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'hA5A5_A5A5;
        push("A.wb_data", DA + F_RD1, 32'hA5A5_A5A5);
        push("A.wb_busy", DA + F_BUSY1, 32'd0);
        push("B.wb_data", DB + F_RD1, 32'd0);
        push("B.wb_busy", DB + F_BUSY1, 32'd1);
        push2("wb_cnt", F_CNT, 32'd1);
        check_all();
        @(negedge clk);
        idle();
        push2("post_wb_data", F_RD1, 32'hA5A5_A5A5);
        push2("post_wb_busy", F_BUSY1, 32'd0);
        push2("post_wb_cnt", F_CNT, 32'd0);
        check_all();

        // Issue and write-back to x3 in one cycle: data lands, pending stays.
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd3;
        wb0_en = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h3333_3333;
        rd_addr = {5'd7, 5'd3};
        push("A.isswb_data", DA + F_RD0, 32'h3333_3333);
        push("B.isswb_data", DB + F_RD0, 32'd0);
        push2("isswb_busy", F_BUSY0, 32'd0);
        check_all();
        @(negedge clk);
        idle();
        push2("isswb_rd", F_RD0, 32'h3333_3333);
        push2("isswb_pend", F_BUSY0, 32'd1);
        push2("isswb_cnt", F_CNT, 32'd1);
        check_all();

        // Flush clears x3; then issue x1, x2, x4 and flush alongside issue x9.
        @(negedge clk);
        flush = 1'b1;
        push2("flush_same_cyc", F_BUSY0, 32'd1);
        check_all();
        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_addr = 5'd1;
        rd_addr = {5'd4, 5'd1};
        push2("flush_cnt", F_CNT, 32'd0);
        check_all();
        @(negedge clk);
        iss_addr = 5'd2;
        push2("cnt1", F_CNT, 32'd1);
        push2("x1_busy", F_BUSY0, 32'd1);
        check_all();
        @(negedge clk);
        iss_addr = 5'd4;
        push2("cnt2", F_CNT, 32'd2);
        check_all();
        @(negedge clk);
        flush = 1'b1; iss_addr = 5'd9;
        rd_addr = {5'd4, 5'd9};
        push2("cnt3", F_CNT, 32'd3);
        push2("x4_busy", F_BUSY1, 32'd1);
        push2("x9_same_cyc", F_BUSY0, 32'd0);
        check_all();
        @(negedge clk);
        idle();
        push2("flushiss_cnt", F_CNT, 32'd1);
        push2("flushiss_x9", F_BUSY0, 32'd1);
        push2("flushiss_x4", F_BUSY1, 32'd0);
        check_all();

        // x20: out of range for RV32E, legal for RV32I.
        @(negedge clk);
        wb0_en = 1'b1; wb0_addr = 5'd20; wb0_data = 32'h1234_5678;
        iss_en = 1'b1; iss_addr = 5'd20;
        rd_addr = {5'd9, 5'd20};
        push2("x20_rd_now", F_RD0, 32'd0);
        push2("x20_busy_now", F_BUSY0, 32'd0);
        check_all();
        @(negedge clk);
        idle();
        dbg_addr = 5'd20;
        push("A.x20_rd", DA + F_RD0, 32'd0);
        push("A.x20_busy", DA + F_BUSY0, 32'd0);
        push("A.x20_cnt", DA + F_CNT, 32'd1);
        push("A.x20_dbg", DA + F_DBG, 32'd0);
        push("B.x20_rd", DB + F_RD0, 32'h1234_5678);
        push("B.x20_busy", DB + F_BUSY0, 32'd1);
        push("B.x20_cnt", DB + F_CNT, 32'd2);
        push("B.x20_dbg", DB + F_DBG, 32'h1234_5678);
        check_all();

        // Both ports to different registers; wb1 clears x9.
        @(negedge clk);
        wb0_en = 1'b1; wb0_addr = 5'd10; wb0_data = 32'hAAAA_0000;
        wb1_en = 1'b1; wb1_addr = 5'd9;  wb1_data = 32'h9999_9999;
        rd_addr = {5'd9, 5'd10};
        push("A.dual_rd0", DA + F_RD0, 32'hAAAA_0000);
        push("A.dual_rd1", DA + F_RD1, 32'h9999_9999);
        push("A.dual_busy1", DA + F_BUSY1, 32'd0);
        push("B.dual_rd0", DB + F_RD0, 32'd0);
        push("B.dual_rd1", DB + F_RD1, 32'd0);
        push("B.dual_busy1", DB + F_BUSY1, 32'd1);
        check_all();
        @(negedge clk);
        idle();
        dbg_addr = 5'd10;
        push2("dual_dbg", F_DBG, 32'hAAAA_0000);
        push2("dual_rd1_post", F_RD1, 32'h9999_9999);
        push2("dual_busy1_post", F_BUSY1, 32'd0);
        push("A.dual_cnt", DA + F_CNT, 32'd0);
        push("B.dual_cnt", DB + F_CNT, 32'd1);
        check_all();

        // Reset overrides a same-cycle write and issue.
        @(negedge clk);
        rst = 1'b1;
        wb0_en = 1'b1; wb0_addr = 5'd11; wb0_data = 32'hBBBB_BBBB;
        iss_en = 1'b1; iss_addr = 5'd11;
        @(negedge clk);
        rst = 1'b0;
        idle();
        rd_addr = {5'd11, 5'd5};
        push2("rst2_rd0", F_RD0, 32'd0);
        push2("rst2_rd1", F_RD1, 32'd0);
        push2("rst2_busy1", F_BUSY1, 32'd0);
        push2("rst2_dbg", F_DBG, 32'd0);
        push2("rst2_cnt", F_CNT, 32'd0);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpr_file.md
# gpr_file

Parametrised general-purpose register file with an integrated write-back scoreboard for the pipelined NPC core. It takes over the GPR storage role in the write-back stage and adds configurable register count (RV32E/RV32I), configurable read-port count, two independent write-back ports (ALU and LSU), optional same-cycle write-to-read bypass, and per-register pending tracking so the decode stage can detect RAW hazards. It also exposes a debug read port for the simulator's register dump.

## Interface
- XLEN, 32, data width of every register.
- NREG, 16, architectural register count; legal values 16 (RV32E) or 32 (RV32I).
- NRP, 2, number of read ports; legal range 1..4.
- BYPASS, 1, 1 = same-cycle write data and pending-clear are forwarded to read ports; 0 = reads see registered state only.

Clocking and reset:
- Clock `sys_clk`. All state updates on its rising edge.
- Reset `sys_rst`: synchronous, active-high.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  reset.
- rd_addr  in  5*NRP  read addresses; port k uses bits [5k+4:5k].
- rd_data  out  XLEN*NRP  read data, combinational; port k uses bits [XLEN*k+XLEN-1:XLEN*k].
- rd_busy  out  NRP  1 = register addressed by port k has a pending producer.
- wb0_en  in  1  ALU write-back strobe.
- wb0_addr  in  5  ALU write-back address.
- wb0_data  in  XLEN  ALU write-back data.
- wb1_en  in  1  LSU write-back strobe.
- wb1_addr  in  5  LSU write-back address.
- wb1_data  in  XLEN  LSU write-back data.
- iss_en  in  1  issue strobe; marks iss_addr pending.
- iss_addr  in  5  destination register of issuing instruction.
- flush  in  1  clear all pending bits (pipeline flush on trap/branch).
- dbg_addr  in  5  debug read address.
- dbg_data  out  XLEN  debug read data, registered state only, never bypassed.
- pend_cnt  out  $clog2(NREG+1)  number of registers currently pending, registered.

## Operation
- Storage: NREG x XLEN registers plus NREG-bit pending vector.
- x0: reads always 0; writes, issues and pending on x0 ignored; rd_busy for x0 always 0.
- Out-of-range address (>= NREG, only when NREG=16): read returns 0, rd_busy 0, write and issue ignored.
- Write: wbN_en with legal non-zero address updates that register at the edge. Both ports same address same cycle: wb1 data wins. Different addresses: both written.
- Write to a non-pending register: data written, pending unchanged.
- Pending update per register r each edge, in priority order:
  - iss_en and iss_addr==r: set (wins over flush and write-back clear).
  - else flush: clear.
  - else write-back (either port) to r: clear.
  - else hold.
- Issue to an already-pending register: stays set (single bit; ordering of multiple producers is decode's responsibility).
- Read, BYPASS=1: if wb1 hits the address -> wb1_data; else if wb0 hits -> wb0_data; else stored value. rd_busy = pending bit AND NOT (any write-back to that address this cycle).
- Read, BYPASS=0: stored value; rd_busy = raw pending bit.
- Issue in the current cycle never affects rd_busy in the same cycle.
- pend_cnt: registered popcount of the next pending vector, so it always equals popcount of the pending vector currently held.

## Timing
- Reset (sys_rst high at an edge): all registers 0, pending vector 0, pend_cnt 0. Consequently rd_data 0, rd_busy 0, dbg_data 0 after reset. Reset overrides all same-cycle writes, issues and flush.
- Write latency: 1 cycle to registered state / dbg_data; 0 cycles to rd_data when BYPASS=1.
- Issue -> rd_busy high: next cycle.
- Write-back -> rd_busy low: same cycle (BYPASS=1) or next cycle (BYPASS=0).
- flush -> all rd_busy low and pend_cnt 0 next cycle, except a same-cycle issue, which leaves that register pending with pend_cnt 1.
- No handshake stalls: every strobe is accepted in the cycle it is asserted.

## Test plan
- Reset then read all addresses on every port -> rd_data 0, rd_busy 0, pend_cnt 0; write x0=0xDEADBEEF -> x0 still reads 0.
- wb0 x5=0x11111111 and wb1 x5=0x22222222 in the same cycle -> with BYPASS=1, rd_data 0x22222222 in that cycle; next cycle dbg_data(x5)=0x22222222.
- Issue x7, wait 3 cycles, wb1 x7=0xA5A5A5A5 -> rd_busy(x7) 1 for 3 cycles; pend_cnt 1; in write-back cycle rd_busy 0 and rd_data 0xA5A5A5A5 (BYPASS=1) or busy 1 and old data (BYPASS=0); pend_cnt 0 next cycle.
- Issue x3 in the same cycle as wb0 to x3 -> x3 data updated, x3 remains pending, pend_cnt 1.
- Issue x1, x2, x4 on consecutive cycles (pend_cnt 1,2,3), then flush together with issue x9 -> next cycle only x9 pending, pend_cnt 1.
- NREG=16: write x20=0x12345678 and issue x20 -> read x20 returns 0, rd_busy 0, pend_cnt unchanged; NREG=32 same stimulus -> x20 reads 0x12345678 and is pending.
